// File: rtl/rn_free_list_pkg.sv
// -----------------------------------------------------------------------------
// rn_free_list_pkg
// Shared sizing, types and helpers for the rename-number free list.
//   RN_WIDTH      : width of a rename number (RN 0 means "not renamed")
//   RN_COUNT      : number of RN values; the list holds RN_COUNT-1 of them
//   rn_t          : one rename number
//   ptr_t         : head/tail pointer, one extra MSB used as the wrap bit
//   LIST_CAPACITY : maximum number of free entries (RN_COUNT-1)
//   popcount2     : number of set bits in a 2-bit request vector
// -----------------------------------------------------------------------------
package rn_free_list_pkg;

   localparam int RN_WIDTH  = 6;
   localparam int RN_COUNT  = 64;
   localparam int PTR_WIDTH = RN_WIDTH + 1;

   typedef logic [RN_WIDTH-1:0]  rn_t;
   typedef logic [PTR_WIDTH-1:0] ptr_t;

   localparam ptr_t LIST_CAPACITY = ptr_t'(RN_COUNT - 1);

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/rn_free_list_checkpoint.sv
// -----------------------------------------------------------------------------
// rn_checkpoint
// Holds the single branch checkpoint of the free-list head pointer.
// Ports:
//   clock, reset    : rising-edge clock, synchronous active-low reset
//   take            : capture take_head as the new checkpoint this cycle
//   take_head       : head value after the jump's allocation
//   resolve         : outstanding branch confirmed, drop the checkpoint
//   flush           : mispredict, the checkpoint is consumed by the top
//   saved_head      : captured head pointer
//   tag_active      : a checkpoint is currently held
// Priority: flush > take > resolve. A take in the same cycle as resolve
// replaces the old checkpoint, so the new one stays active.
// -----------------------------------------------------------------------------
module rn_checkpoint
   import rn_free_list_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic take,
   input  ptr_t take_head,
   input  logic resolve,
   input  logic flush,
   output ptr_t saved_head,
   output logic tag_active
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         saved_head <= '0;
         tag_active <= 1'b0;
      end else if (flush) begin
         // The top restores head from saved_head; the checkpoint is spent.
         tag_active <= 1'b0;
      end else if (take) begin
         saved_head <= take_head;
         tag_active <= 1'b1;
      end else if (resolve) begin
         tag_active <= 1'b0;
      end
   end

endmodule

// File: rtl/rn_free_list.sv
// -----------------------------------------------------------------------------
// rn_free_list
// Circular free list of physical register tags for the dual-issue renamer,
// with one branch checkpoint for single-cycle rollback on mispredict.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-low reset
//   alloc_req[1:0]   : slot i requests one RN (slot 0 older)
//   alloc_rn[2]      : RN offered to slot i (0 when slot i does not request)
//   stop             : stall; no allocation or checkpoint takes effect
//   checkpoint_req   : a jump is being renamed this cycle
//   checkpoint_slot  : 0 = snapshot after slot 0, 1 = after both slots
//   resolve          : branch confirmed, drop the checkpoint
//   flush            : mispredict, restore head from the checkpoint
//   free_valid[1:0]  : commit port i returns free_rn[i]
//   free_rn[2]       : RN returned by commit port i (0 is ignored)
//   tag_active       : a checkpoint is held
//   free_count       : number of free entries (registered pointers)
//   overflow_err     : sticky, a free was dropped because the list was full
// -----------------------------------------------------------------------------
module rn_free_list
   import rn_free_list_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          alloc_req,
   output rn_t                 alloc_rn [2],
   output logic                stop,
   input  logic                checkpoint_req,
   input  logic                checkpoint_slot,
   input  logic                resolve,
   input  logic                flush,
   input  logic [1:0]          free_valid,
   input  rn_t                 free_rn [2],
   output logic                tag_active,
   output logic [RN_WIDTH:0]   free_count,
   output logic                overflow_err
);

   rn_t  entries [RN_COUNT];
   ptr_t head;
   ptr_t tail;
   ptr_t saved_head;

   ptr_t need;
   rn_t  read_idx0;
   rn_t  read_idx1;
   ptr_t room;
   logic nonzero0, nonzero1;
   logic accept0, accept1;
   logic drop;
   rn_t  write_idx0;
   rn_t  write_idx1;
   ptr_t write_count;
   ptr_t take_head;
   logic take;

   assign free_count = tail - head;
   assign need       = ptr_t'(popcount2(alloc_req));

   // Stall covers: not enough free entries, a second jump while one is still
   // unresolved, and the flush cycle itself.
   assign stop = (need > free_count)
              || (checkpoint_req && tag_active && !resolve)
              || flush;

   // Allocation read ports, combinational from the registered head.
   assign read_idx0 = head[RN_WIDTH-1:0];
   assign read_idx1 = read_idx0 + rn_t'(1);

   always_comb begin
      alloc_rn[0] = '0;
      alloc_rn[1] = '0;
      if (alloc_req[0]) begin
         alloc_rn[0] = entries[read_idx0];
      end
      if (alloc_req[1]) begin
         alloc_rn[1] = alloc_req[0] ? entries[read_idx1] : entries[read_idx0];
      end
   end

   // Free acceptance is judged against the start-of-cycle count so that the
   // list can never claim more than LIST_CAPACITY entries.
   assign room      = LIST_CAPACITY - free_count;
   assign nonzero0  = free_valid[0] && (free_rn[0] != '0);
   assign nonzero1  = free_valid[1] && (free_rn[1] != '0);
   assign accept0   = nonzero0 && (room != '0);
   assign accept1   = nonzero1 && (room > ptr_t'(accept0));
   assign drop      = (nonzero0 && !accept0) || (nonzero1 && !accept1);

   assign write_idx0  = tail[RN_WIDTH-1:0];
   assign write_idx1  = write_idx0 + rn_t'(accept0);
   assign write_count = ptr_t'(accept0) + ptr_t'(accept1);

   // Checkpoint is the head after the jump: after slot 0 only, or after both.
   assign take      = checkpoint_req && !stop;
   assign take_head = head + (checkpoint_slot ? need : ptr_t'(alloc_req[0]));

   rn_checkpoint u_checkpoint (
      .clock      (clock),
      .reset      (reset),
      .take       (take),
      .take_head  (take_head),
      .resolve    (resolve),
      .flush      (flush),
      .saved_head (saved_head),
      .tag_active (tag_active)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < RN_COUNT; i++) begin
            // The last slot is the spare that keeps full and empty distinct.
            entries[i] <= (i == RN_COUNT - 1) ? rn_t'(0) : rn_t'(i + 1);
         end
         head         <= '0;
         tail         <= LIST_CAPACITY;
         overflow_err <= 1'b0;
      end else begin
         if (accept0) begin
            entries[write_idx0] <= free_rn[0];
         end
         if (accept1) begin
            entries[write_idx1] <= free_rn[1];
         end
         tail <= tail + write_count;

         if (flush) begin
            // Flush without a checkpoint leaves head untouched.
            if (tag_active) begin
               head <= saved_head;
            end
         end else if (!stop) begin
            head <= head + need;
         end

         if (drop) begin
            overflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rn_free_list.sv
// -----------------------------------------------------------------------------
// tb_rn_free_list
// Directed test of rn_free_list: reset state, allocation, exhaustion and
// wrap-around, zero-RN frees, checkpoint/flush rollback, re-checkpoint with
// resolve, overflow detection and reset of pending state.
// -----------------------------------------------------------------------------
module tb_rn_free_list;
   import rn_free_list_pkg::*;

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]        alloc_req;
   rn_t               alloc_rn [2];
   logic              stop;
   logic              checkpoint_req;
   logic              checkpoint_slot;
   logic              resolve;
   logic              flush;
   logic [1:0]        free_valid;
   rn_t               free_rn [2];
   logic              tag_active;
   logic [RN_WIDTH:0] free_count;
   logic              overflow_err;

   int total = 0;
   int bad   = 0;

   rn_free_list dut (
      .clock           (clock),
      .reset           (reset),
      .alloc_req       (alloc_req),
      .alloc_rn        (alloc_rn),
      .stop            (stop),
      .checkpoint_req  (checkpoint_req),
      .checkpoint_slot (checkpoint_slot),
      .resolve         (resolve),
      .flush           (flush),
      .free_valid      (free_valid),
      .free_rn         (free_rn),
      .tag_active      (tag_active),
      .free_count      (free_count),
      .overflow_err    (overflow_err)
   );

   // driver tasks
   task automatic idle();
      alloc_req       = 2'b00;
      checkpoint_req  = 1'b0;
      checkpoint_slot = 1'b0;
      resolve         = 1'b0;
      flush           = 1'b0;
      free_valid      = 2'b00;
      free_rn[0]      = '0;
      free_rn[1]      = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      settle();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (free_count !== 7'd63) begin bad++; $display("FAIL reset_free_count: got %0d want 63", free_count); end
      total++; if (alloc_rn[0] !== 6'd0 || alloc_rn[1] !== 6'd0) begin bad++; $display("FAIL reset_alloc_rn: got %0d,%0d want 0,0", alloc_rn[0], alloc_rn[1]); end
      total++; if (tag_active !== 1'b0 || stop !== 1'b0 || overflow_err !== 1'b0) begin bad++; $display("FAIL reset_flags: tag=%b stop=%b ovf=%b want 0,0,0", tag_active, stop, overflow_err); end
      alloc_req = 2'b11;
      settle();
      total++; if (alloc_rn[0] !== 6'd1 || alloc_rn[1] !== 6'd2) begin bad++; $display("FAIL first_pair: got %0d,%0d want 1,2", alloc_rn[0], alloc_rn[1]); end
      tick();
      idle();
      settle();
      total++; if (free_count !== 7'd61) begin bad++; $display("FAIL first_pair_count: got %0d want 61", free_count); end
      alloc_req = 2'b10;
      settle();
      total++; if (alloc_rn[0] !== 6'd0 || alloc_rn[1] !== 6'd3) begin bad++; $display("FAIL slot1_only: got %0d,%0d want 0,3", alloc_rn[0], alloc_rn[1]); end
      idle();
   endtask

   task automatic test_exhaust_wrap();
      do_reset();
      alloc_req = 2'b11;
      repeat (31) tick();
      settle();
      total++; if (stop !== 1'b1) begin bad++; $display("FAIL exhaust_stop_pair: got %b want 1", stop); end
      tick();
      total++; if (free_count !== 7'd1) begin bad++; $display("FAIL stall_holds_head: got %0d want 1", free_count); end
      alloc_req = 2'b01;
      settle();
      total++; if (stop !== 1'b0 || alloc_rn[0] !== 6'd63) begin bad++; $display("FAIL last_rn: stop=%b rn=%0d want 0,63", stop, alloc_rn[0]); end
      tick();
      idle();
      settle();
      total++; if (free_count !== 7'd0) begin bad++; $display("FAIL empty_count: got %0d want 0", free_count); end
      alloc_req = 2'b01;
      settle();
      total++; if (stop !== 1'b1) begin bad++; $display("FAIL empty_stop: got %b want 1", stop); end
      idle();
      free_valid = 2'b11;
      free_rn[0] = 6'd5;
      free_rn[1] = 6'd9;
      alloc_req  = 2'b01;
      settle();
      total++; if (stop !== 1'b1) begin bad++; $display("FAIL no_free_bypass: got %b want 1", stop); end
      tick();
      idle();
      settle();
      total++; if (free_count !== 7'd2) begin bad++; $display("FAIL refill_count: got %0d want 2", free_count); end
      alloc_req = 2'b11;
      settle();
      total++; if (alloc_rn[0] !== 6'd5 || alloc_rn[1] !== 6'd9 || stop !== 1'b0) begin bad++; $display("FAIL wrap_alloc: got %0d,%0d stop=%b want 5,9,0", alloc_rn[0], alloc_rn[1], stop); end
      tick();
      idle();
      settle();
      total++; if (free_count !== 7'd0) begin bad++; $display("FAIL wrap_empty: got %0d want 0", free_count); end
   endtask

   task automatic test_zero_free();
      do_reset();
      alloc_req = 2'b11;
      tick();
      idle();
      free_valid = 2'b11;
      tick();
      idle();
      settle();
      total++; if (free_count !== 7'd61 || overflow_err !== 1'b0) begin bad++; $display("FAIL zero_free: count=%0d ovf=%b want 61,0", free_count, overflow_err); end
      free_valid = 2'b11;
      free_rn[1] = 6'd1;
      tick();
      idle();
      settle();
      total++; if (free_count !== 7'd62) begin bad++; $display("FAIL mixed_free: got %0d want 62", free_count); end
   endtask

   task automatic test_checkpoint_flush();
      do_reset();
      checkpoint_req  = 1'b1;
      checkpoint_slot = 1'b0;
      alloc_req       = 2'b11;
      settle();
      total++; if (stop !== 1'b0 || alloc_rn[0] !== 6'd1 || alloc_rn[1] !== 6'd2) begin bad++; $display("FAIL ckpt_alloc: stop=%b rn=%0d,%0d want 0,1,2", stop, alloc_rn[0], alloc_rn[1]); end
      tick();
      idle();
      settle();
      total++; if (tag_active !== 1'b1) begin bad++; $display("FAIL ckpt_tag: got %b want 1", tag_active); end
      alloc_req = 2'b11;
      settle();
      total++; if (alloc_rn[0] !== 6'd3 || alloc_rn[1] !== 6'd4) begin bad++; $display("FAIL spec_alloc: got %0d,%0d want 3,4", alloc_rn[0], alloc_rn[1]); end
      tick();
      idle();
      flush     = 1'b1;
      alloc_req = 2'b11;
      settle();
      total++; if (stop !== 1'b1) begin bad++; $display("FAIL flush_stop: got %b want 1", stop); end
      tick();
      idle();
      alloc_req = 2'b01;
      settle();
      total++; if (alloc_rn[0] !== 6'd2 || free_count !== 7'd62 || tag_active !== 1'b0) begin bad++; $display("FAIL flush_restore: rn=%0d count=%0d tag=%b want 2,62,0", alloc_rn[0], free_count, tag_active); end
      idle();
   endtask

   task automatic test_flush_idle();
      do_reset();
      flush     = 1'b1;
      alloc_req = 2'b11;
      tick();
      idle();
      alloc_req = 2'b01;
      settle();
      total++; if (free_count !== 7'd63 || alloc_rn[0] !== 6'd1 || tag_active !== 1'b0) begin bad++; $display("FAIL flush_noop: count=%0d rn=%0d tag=%b want 63,1,0", free_count, alloc_rn[0], tag_active); end
      idle();
   endtask

   task automatic test_back_to_back_checkpoint();
      do_reset();
      checkpoint_req  = 1'b1;
      checkpoint_slot = 1'b1;
      alloc_req       = 2'b11;
      tick();
      idle();
      checkpoint_req  = 1'b1;
      checkpoint_slot = 1'b1;
      alloc_req       = 2'b01;
      settle();
      total++; if (stop !== 1'b1) begin bad++; $display("FAIL second_ckpt_stop: got %b want 1", stop); end
      resolve = 1'b1;
      settle();
      total++; if (stop !== 1'b0 || alloc_rn[0] !== 6'd3) begin bad++; $display("FAIL resolve_ckpt: stop=%b rn=%0d want 0,3", stop, alloc_rn[0]); end
      tick();
      idle();
      settle();
      total++; if (tag_active !== 1'b1 || free_count !== 7'd60) begin bad++; $display("FAIL new_ckpt: tag=%b count=%0d want 1,60", tag_active, free_count); end
      alloc_req = 2'b11;
      tick();
      idle();
      flush = 1'b1;
      tick();
      idle();
      alloc_req = 2'b01;
      settle();
      total++; if (alloc_rn[0] !== 6'd4 || free_count !== 7'd60) begin bad++; $display("FAIL new_saved_head: rn=%0d count=%0d want 4,60", alloc_rn[0], free_count); end
      // resolve alone drops the checkpoint; a later flush must not move head
      checkpoint_req = 1'b1;
      alloc_req      = 2'b11;
      tick();
      idle();
      resolve = 1'b1;
      tick();
      idle();
      settle();
      total++; if (tag_active !== 1'b0) begin bad++; $display("FAIL resolve_clear: got %b want 0", tag_active); end
      flush = 1'b1;
      tick();
      idle();
      alloc_req = 2'b01;
      settle();
      total++; if (alloc_rn[0] !== 6'd6) begin bad++; $display("FAIL flush_after_resolve: got %0d want 6", alloc_rn[0]); end
      idle();
   endtask

   task automatic test_overflow();
      do_reset();
      free_valid = 2'b01;
      free_rn[0] = 6'd7;
      tick();
      idle();
      settle();
      total++; if (overflow_err !== 1'b1 || free_count !== 7'd63) begin bad++; $display("FAIL overflow_full: ovf=%b count=%0d want 1,63", overflow_err, free_count); end
      tick();
      total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b want 1", overflow_err); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      settle();
      total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL overflow_reset: got %b want 0", overflow_err); end
      alloc_req = 2'b01;
      tick();
      idle();
      free_valid = 2'b11;
      free_rn[0] = 6'd1;
      free_rn[1] = 6'd7;
      tick();
      idle();
      settle();
      total++; if (free_count !== 7'd63 || overflow_err !== 1'b1) begin bad++; $display("FAIL partial_overflow: count=%0d ovf=%b want 63,1", free_count, overflow_err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      checkpoint_req = 1'b1;
      alloc_req      = 2'b11;
      tick();
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      alloc_req = 2'b11;
      settle();
      total++; if (tag_active !== 1'b0 || free_count !== 7'd63 || alloc_rn[0] !== 6'd1) begin bad++; $display("FAIL reset_mid: tag=%b count=%0d rn=%0d want 0,63,1", tag_active, free_count, alloc_rn[0]); end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_exhaust_wrap();
      test_zero_free();
      test_checkpoint_flush();
      test_flush_idle();
      test_back_to_back_checkpoint();
      test_overflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rn_free_list.md
# rn_free_list

Allocates rename numbers (RN) for the dual-issue renamer and reclaims them on commit. It is a circular free list of physical register tags feeding both rename query ports. It keeps one branch checkpoint, so speculative allocations are rolled back in one cycle on a mispredict flush. It generates the `stop` stall that the renamer consumes.

## Interface
- `RN_WIDTH`, 6, width of a rename number; RN 0 is reserved as "not renamed".
- `RN_COUNT`, 64, number of RN values; the list holds `RN_COUNT-1` entries (1..63).
- `clock  in  1  ` single clock, all state on rising edge.
- `reset  in  1  ` synchronous, active-low.
- `alloc_req  in  2  ` slot i requests one RN (slot 0 older).
- `alloc_rn[2]  out  RN_WIDTH  ` RN granted to slot i; 0 when slot i does not request.
- `stop  out  1  ` stall for the renamer; no allocation takes effect this cycle.
- `checkpoint_req  in  1  ` a jump is being renamed this cycle.
- `checkpoint_slot  in  1  ` 0: snapshot after slot 0's allocation (JN); 1: snapshot after both slots (NJ/JJ).
- `resolve  in  1  ` the outstanding branch is confirmed; drop the checkpoint.
- `flush  in  1  ` mispredict; restore the checkpoint.
- `free_valid  in  2  ` commit port i returns an RN.
- `free_rn[2]  in  RN_WIDTH  ` RN returned by commit port i.
- `tag_active  out  1  ` a checkpoint is held; the renamer stamps it on query tags.
- `free_count  out  RN_WIDTH+1  ` number of free entries.
- `overflow_err  out  1  ` sticky; a free was dropped because the list was full.

## Operation
- Storage: `entries[RN_COUNT]` of RN_WIDTH bits. `head` (allocation) and `tail` (free) pointers are RN_WIDTH+1 bits wide, with the MSB as the wrap bit. `free_count = tail - head`, taken modulo 2^(RN_WIDTH+1).
- Reset state: `entries[i] = i+1` for i = 0..62; `head = 0`; `tail = 63`; `free_count = 63`; `tag_active = 0`; `saved_head = 0`; `overflow_err = 0`; `stop = 0`; `alloc_rn = 0`.
- Allocation:
  - `need = popcount(alloc_req)`.
  - The first requesting slot gets `entries[head]`. If both slots request, slot 1 gets `entries[head+1]`.
  - `alloc_rn` is combinational from `head`.
- `stop` is asserted when `need > free_count`, or `checkpoint_req && tag_active && !resolve`, or `flush`.
  - When `!stop`, `head <= head + need`. Otherwise `head` holds and the requests are re-presented next cycle (all-or-nothing).
- Free:
  - Valid ports carrying a nonzero RN are written at `tail`, port 0 first.
  - `tail <= tail + count_written`.
  - Frees with `free_rn == 0` are ignored.
  - Any free that would make `free_count > 63` is dropped and sets `overflow_err`.
- Checkpoint: on `checkpoint_req && !stop`:
  - `saved_head <= head + (checkpoint_slot ? need : popcount(alloc_req[0]))`.
  - `tag_active <= 1`.
- Resolve: `tag_active <= 0`. If `checkpoint_req` is asserted in the same cycle, the new checkpoint is taken; resolve has priority in clearing the old one.
- Flush:
  - `head <= saved_head` and `tag_active <= 0`.
  - Allocations and checkpoints in the same cycle are suppressed.
  - Frees in the same cycle are applied.
  - Flush with `tag_active = 0` is a no-op except for `stop`.
- Resolve and flush in the same cycle: flush wins.

## Timing
- Allocation latency is 0: `alloc_rn` is valid in the same cycle as `alloc_req`, and `head` updates at the next edge.
- A freed RN becomes allocatable in the cycle after `free_valid`. There is no same-cycle bypass from free to allocate.
- `free_count` and `stop` reflect the registered pointers at the start of the cycle. Frees in the current cycle do not relieve `stop`.
- After flush, the restored `head` is visible on `alloc_rn` in the next cycle.
- Reset sampled low mid-operation returns every register to its reset value at that edge, including a pending checkpoint.

## Structure
- Add `RN_WIDTH` and `RN_COUNT` to the shared `global_variables` package, next to `XLEN`.
- Add a `rn_t` typedef (`logic [RN_WIDTH-1:0]`) to `structures`.
- One natural sub-module: `rn_checkpoint`, which holds `saved_head` and `tag_active` and applies the checkpoint/resolve/flush priority.
- The pointer arithmetic and the storage stay in the top module.

## Test plan
- Reset -> `free_count = 63`, `alloc_rn = 0`, `tag_active = 0`. Then `alloc_req = 2'b11` -> `alloc_rn = {1, 2}`, and next cycle `free_count = 61`.
- Allocate 31 pairs (62 RNs), then `alloc_req = 2'b11` -> `stop = 1` (free_count 1). Then `alloc_req = 2'b01` -> RN 63, `stop = 0`. Next cycle `free_count = 0`.
- Exhaust the list, then free RNs 5 and 9 on both ports -> next cycle `free_count = 2`, and `alloc_req = 2'b11` -> `alloc_rn = {5, 9}`. Check that `head` wrapped through 63.
- `checkpoint_req = 1`, `checkpoint_slot = 0`, `alloc_req = 2'b11` from reset -> `tag_active = 1`. Allocate 2 more, then `flush` -> next cycle `alloc_rn[0] = 2`, `free_count = 62`.
- `tag_active = 1` plus a second `checkpoint_req` -> `stop = 1`. Assert `resolve` with it in the same cycle -> `stop = 0` and the new `saved_head` is taken.
- `free_rn = 7` with `free_count = 63` -> `overflow_err = 1`, sticky, `tail` unchanged. Then drive `reset = 0` for one edge -> `overflow_err = 0`.
